// File: rtl/cmp_serial_pkg.sv
// Shared types and helpers for the digit-serial EQ/GE comparator.
package cmp_serial_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } cmp_state_e;

  // Slice counter width; never narrower than one bit so NDIG = 1 still elaborates.
  function automatic int cnt_width(input int ndig);
    return (ndig <= 1) ? 1 : $clog2(ndig);
  endfunction

endpackage

// File: rtl/cmp_eqge_serial_cmp.sv
// Combinational LSB-first EQ/GE comparator used as the per-slice comparator.
// speed 0 ripples bit by bit; speed 1/2 combine (eq,gt) pairs in a log-depth tree.
module CmpEQGE #(
  parameter int width = 8,
  parameter int speed = 2
) (
  input  logic [width-1:0] a_i,
  input  logic [width-1:0] b_i,
  output logic             eq_o,
  output logic             ge_o
);

  logic eq_acc;
  logic gt_acc;

  generate
    if (speed == 0) begin : g_serial
      always_comb begin
        eq_acc = 1'b1;
        gt_acc = 1'b0;
        for (int i = 0; i < width; i++) begin
          gt_acc = (a_i[i] & ~b_i[i]) | (~(a_i[i] ^ b_i[i]) & gt_acc);
          eq_acc = eq_acc & ~(a_i[i] ^ b_i[i]);
        end
      end
    end else begin : g_tree
      // Only the full-width prefix is needed, where Brent-Kung and Sklansky coincide.
      localparam int LV = (width > 1) ? $clog2(width) : 0;
      localparam int NP = 1 << LV;
      logic [NP-1:0] eqv;
      logic [NP-1:0] gtv;

      always_comb begin
        eqv = '1;
        gtv = '0;
        for (int i = 0; i < width; i++) begin
          eqv[i] = ~(a_i[i] ^ b_i[i]);
          gtv[i] = a_i[i] & ~b_i[i];
        end
        for (int l = 0; l < LV; l++) begin
          for (int i = 0; i < NP; i += (2 << l)) begin
            gtv[i] = gtv[i + (1 << l)] | (eqv[i + (1 << l)] & gtv[i]);
            eqv[i] = eqv[i] & eqv[i + (1 << l)];
          end
        end
        eq_acc = eqv[0];
        gt_acc = gtv[0];
      end
    end
  endgenerate

  assign eq_o = eq_acc;
  assign ge_o = eq_acc | gt_acc;

endmodule

// File: rtl/cmp_eqge_serial.sv
// Digit-serial MSB-first EQ/GE comparator with valid/ready on both sides.
// CMP_SERIAL_EARLY_EXIT_EN: stop at the first differing slice instead of scanning all slices.
module cmp_eqge_serial
  import cmp_serial_pkg::*;
#(
  parameter int width = 32,
  parameter int digit = 8,
  parameter int speed = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [width-1:0] a_i,
  input  logic [width-1:0] b_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             eq_o,
  output logic             ge_o
);

  localparam int NDIG = width / digit;
  localparam int CW   = cnt_width(NDIG);
  localparam logic [CW-1:0] CNT_TOP = CW'(NDIG - 1);

  generate
    if (digit < 1 || digit > width || (width % digit) != 0) begin : g_bad_cfg
      $error("cmp_eqge_serial: width must be a nonzero multiple of digit");
    end
  endgenerate

  cmp_state_e       state_q, state_d;
  logic [width-1:0] a_q, b_q;
  logic [width-1:0] a_sh, b_sh;
  logic [digit-1:0] a_sl, b_sl;
  logic [CW-1:0]    cnt_q;
  logic             sl_eq, sl_ge;
  logic             finish, eq_d, ge_d;

  assign a_sh = a_q >> (int'(cnt_q) * digit);
  assign b_sh = b_q >> (int'(cnt_q) * digit);
  assign a_sl = a_sh[digit-1:0];
  assign b_sl = b_sh[digit-1:0];

  CmpEQGE #(
    .width(digit),
    .speed(speed)
  ) u_slice (
    .a_i (a_sl),
    .b_i (b_sl),
    .eq_o(sl_eq),
    .ge_o(sl_ge)
  );

`ifdef CMP_SERIAL_EARLY_EXIT_EN
  always_comb begin
    finish = 1'b0;
    eq_d   = 1'b0;
    ge_d   = 1'b0;
    if (!sl_eq) begin
      finish = 1'b1;
      ge_d   = sl_ge;
    end else if (cnt_q == '0) begin
      finish = 1'b1;
      eq_d   = 1'b1;
      ge_d   = 1'b1;
    end
  end
`else
  // The first difference is latched in decided_q/ge_acc_q; later slices cannot override it.
  logic decided_q;
  logic ge_acc_q;

  always_comb begin
    finish = 1'b0;
    eq_d   = 1'b0;
    ge_d   = 1'b0;
    if (cnt_q == '0) begin
      finish = 1'b1;
      eq_d   = ~decided_q & sl_eq;
      ge_d   = decided_q ? ge_acc_q : sl_ge;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      decided_q <= 1'b0;
      ge_acc_q  <= 1'b0;
    end else if (state_q == IDLE) begin
      decided_q <= 1'b0;
    end else if (state_q == BUSY && !decided_q && !sl_eq) begin
      decided_q <= 1'b1;
      ge_acc_q  <= sl_ge;
    end
  end
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid_i)  state_d = BUSY;
      BUSY:    if (finish)      state_d = DONE;
      DONE:    if (out_ready_i) state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_q   <= '0;
      b_q   <= '0;
      cnt_q <= '0;
      eq_o  <= 1'b0;
      ge_o  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            a_q   <= a_i;
            b_q   <= b_i;
            cnt_q <= CNT_TOP;
          end
        end
        BUSY: begin
          if (finish) begin
            eq_o <= eq_d;
            ge_o <= ge_d;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_eqge_serial.sv
// Randomized self-checking bench for cmp_eqge_serial (32/8 instance plus an 8/8 single-slice instance).
module tb_cmp_eqge_serial;

  localparam int W = 32;
  localparam int D = 8;
  localparam int N = W / D;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, eq_o, ge_o;
  logic [31:0] a_i, b_i;
  logic        in_valid8, in_ready8, out_valid8, out_ready8, eq8, ge8;
  logic [7:0]  a8, b8;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cmp_eqge_serial #(.width(W), .digit(D), .speed(2)) dut (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .a_i(a_i), .b_i(b_i), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .eq_o(eq_o), .ge_o(ge_o)
  );

  cmp_eqge_serial #(.width(8), .digit(8), .speed(0)) dut8 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid8), .in_ready_o(in_ready8),
    .a_i(a8), .b_i(b8), .out_valid_o(out_valid8), .out_ready_i(out_ready8),
    .eq_o(eq8), .ge_o(ge8)
  );

  // Expected slices examined: smallest prefix length (in slices, from the MSB) at which A and B differ.
  function automatic int model_lat(input logic [31:0] a, input logic [31:0] b);
    int first;
    first = N;
    for (int t = N; t >= 1; t--)
      if ((a >> (W - D * t)) != (b >> (W - D * t))) first = t;
`ifdef CMP_SERIAL_EARLY_EXIT_EN
    return first;
`else
    return (first > 0) ? N : N;
`endif
  endfunction

  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       output logic eq, output logic ge, output int lat, output bit to);
    int g;
    to = 1'b0; lat = 0; g = 0;
    @(negedge clk);
    a_i = a; b_i = b; in_valid = 1'b1;
    while (!in_ready && g < 40) begin @(negedge clk); g++; end
    if (!in_ready) to = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    do begin @(posedge clk); #1; lat++; end while (!out_valid && lat < 64);
    if (!out_valid) to = 1'b1;
    eq = eq_o; ge = ge_o;
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic do_op8(input logic [7:0] a, input logic [7:0] b,
                        output logic eq, output logic ge, output int lat, output bit to);
    to = 1'b0; lat = 0;
    @(negedge clk);
    a8 = a; b8 = b; in_valid8 = 1'b1;
    if (!in_ready8) to = 1'b1;
    @(posedge clk);
    #1 in_valid8 = 1'b0;
    do begin @(posedge clk); #1; lat++; end while (!out_valid8 && lat < 16);
    if (!out_valid8) to = 1'b1;
    eq = eq8; ge = ge8;
    @(negedge clk) out_ready8 = 1'b1;
    @(posedge clk);
    #1 out_ready8 = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    total++; if (in_ready !== 1'b1)  begin bad++; $display("[TB] FAIL rst_in_ready got=%b want=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_out_valid got=%b want=0", out_valid); end
    total++; if ({eq_o, ge_o} !== 2'b00) begin bad++; $display("[TB] FAIL rst_eq_ge got=%b want=00", {eq_o, ge_o}); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
      begin bad++; $display("[TB] FAIL post_rst got=%b%b want=10", in_ready, out_valid); end
  endtask

  task automatic test_directed();
    logic [31:0] va [3] = '{32'h12345678, 32'h80000000, 32'h12345677};
    logic [31:0] vb [3] = '{32'h12345678, 32'h7FFFFFFF, 32'h12345678};
    logic eq, ge; int lat; bit to;
    for (int i = 0; i < 3; i++) begin
      do_op(va[i], vb[i], eq, ge, lat, to);
      total++; if (to)  begin bad++; $display("[TB] FAIL dir_timeout idx=%0d got=timeout want=result", i); end
      total++; if (eq !== (va[i] == vb[i])) begin bad++; $display("[TB] FAIL dir_eq idx=%0d got=%b want=%b", i, eq, va[i] == vb[i]); end
      total++; if (ge !== (va[i] >= vb[i])) begin bad++; $display("[TB] FAIL dir_ge idx=%0d got=%b want=%b", i, ge, va[i] >= vb[i]); end
      total++; if (lat != model_lat(va[i], vb[i]))
        begin bad++; $display("[TB] FAIL dir_lat idx=%0d got=%0d want=%0d", i, lat, model_lat(va[i], vb[i])); end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b; logic eq, ge; int lat; bit to; int s;
    for (int i = 0; i < 150; i++) begin
      a = $urandom;
      case ($urandom_range(0, 2))
        0: b = $urandom;
        1: b = a;
        default: begin
          s = $urandom_range(0, N - 1);
          b = a ^ (32'($urandom_range(1, 255)) << (8 * s));
        end
      endcase
      do_op(a, b, eq, ge, lat, to);
      total++;
      if (to || eq !== (a == b) || ge !== (a >= b) || lat != model_lat(a, b)) begin
        bad++;
        $display("[TB] FAIL rand a=%h b=%h got eq=%b ge=%b lat=%0d to=%0b want eq=%b ge=%b lat=%0d",
                 a, b, eq, ge, lat, to, a == b, a >= b, model_lat(a, b));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic eq, ge; int lat; bit to;
    for (int i = 0; i < 4; i++) begin
      do_op(32'(i * 3), 32'(i * 2), eq, ge, lat, to);
      total++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || to)
        begin bad++; $display("[TB] FAIL b2b_idle idx=%0d got rdy=%b vld=%b want rdy=1 vld=0", i, in_ready, out_valid); end
      total++; if (ge !== 1'b1 || eq !== (i == 0))
        begin bad++; $display("[TB] FAIL b2b_res idx=%0d got eq=%b ge=%b want eq=%b ge=1", i, eq, ge, i == 0); end
    end
  endtask

  task automatic test_backpressure();
    int g;
    g = 0;
    @(negedge clk);
    a_i = 32'h11; b_i = 32'h22; in_valid = 1'b1;
    @(posedge clk); #1;
    while (!out_valid && g < 20) begin @(posedge clk); #1; g++; end
    total++; if (!out_valid) begin bad++; $display("[TB] FAIL bp_timeout got=%b want=1", out_valid); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk) begin a_i = $urandom; b_i = $urandom; end
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {eq_o, ge_o} !== 2'b00) begin
        bad++;
        $display("[TB] FAIL bp_hold cyc=%0d got vld=%b rdy=%b eqge=%b%b want vld=1 rdy=0 eqge=00",
                 i, out_valid, in_ready, eq_o, ge_o);
      end
    end
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk);
    #1 begin out_ready = 1'b0; in_valid = 1'b0; end
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin bad++; $display("[TB] FAIL bp_release got vld=%b rdy=%b want vld=0 rdy=1", out_valid, in_ready); end
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b1)
      begin bad++; $display("[TB] FAIL bp_no_second_accept got rdy=%b want=1", in_ready); end
  endtask

  task automatic test_reset_midbusy();
    logic eq, ge; int lat; bit to;
    do_op(32'd7, 32'd7, eq, ge, lat, to);
    total++; if ({eq, ge} !== 2'b11 || to) begin bad++; $display("[TB] FAIL pre_rst got=%b%b want=11", eq, ge); end
    @(negedge clk);
    a_i = 32'hFF000000; b_i = 32'h00000001; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL busy_rdy got=%b want=0", in_ready); end
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || {eq_o, ge_o} !== 2'b00 || in_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL abort got vld=%b eqge=%b%b rdy=%b want vld=0 eqge=00 rdy=1", out_valid, eq_o, ge_o, in_ready);
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL abort_no_result got=%b want=0", out_valid); end
    do_op(32'd5, 32'd5, eq, ge, lat, to);
    total++; if ({eq, ge} !== 2'b11 || to || lat != model_lat(32'd5, 32'd5))
      begin bad++; $display("[TB] FAIL after_rst got eq=%b ge=%b lat=%0d want eq=1 ge=1 lat=%0d", eq, ge, lat, model_lat(32'd5, 32'd5)); end
  endtask

  task automatic test_single_slice();
    logic [7:0] a, b; logic eq, ge; int lat; bit to;
    for (int i = 0; i < 300; i++) begin
      case (i)
        0: begin a = 8'h00; b = 8'h00; end
        1: begin a = 8'hFF; b = 8'hFF; end
        2: begin a = 8'h00; b = 8'hFF; end
        3: begin a = 8'hFF; b = 8'h00; end
        default: begin a = 8'($urandom); b = (i % 4 == 0) ? a : 8'($urandom); end
      endcase
      do_op8(a, b, eq, ge, lat, to);
      total++;
      if (to || eq !== (a == b) || ge !== (a >= b) || lat != 1) begin
        bad++;
        $display("[TB] FAIL slice8 a=%h b=%h got eq=%b ge=%b lat=%0d want eq=%b ge=%b lat=1",
                 a, b, eq, ge, lat, a == b, a >= b);
      end
    end
  endtask

  initial begin
    rst_n = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; a_i = '0; b_i = '0;
    in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_backpressure();
    test_reset_midbusy();
    test_single_slice();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
